// File: rtl/clock_mode_ctrl.sv
// Mode controller for a digital clock. It runs, sets the time and alarm, and rings the buzzer.
// Button edges drive a seven-state mode FSM, and an alarm match arms a 60-second buzzer.
module clock_mode_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1s,
    input  logic        set_btn,
    input  logic        add_btn,
    input  logic        beep_btn,
    input  logic [23:0] cur_time,
    input  logic [23:0] alarm_time,
    output logic [2:0]  cur_inc,
    output logic [2:0]  alarm_inc,
    output logic        disp_alarm,
    output logic [2:0]  flash,
    output logic        run_mode,
    output logic        beep_en,
    output logic        beep
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_SEC  = 3'd1,
        SET_MIN  = 3'd2,
        SET_HOUR = 3'd3,
        ALM_SEC  = 3'd4,
        ALM_MIN  = 3'd5,
        ALM_HOUR = 3'd6
    } state_t;

    localparam logic [4:0] IDLE_LAST = 5'd29;
    localparam logic [5:0] RING_LAST = 6'd59;

    state_t      state_reg, state_next;
    logic [2:0]  btn, btn_prev_reg, btn_edge;
    logic        armed_reg;
    logic [4:0]  idle_cnt_reg, idle_next;
    logic        match_reg, match_now;
    logic        ringing_reg, ringing_next;
    logic        phase_reg, phase_next;
    logic [5:0]  ring_cnt_reg, ring_cnt_next;
    logic        beep_en_reg, beep_en_next;
    logic [2:0]  cur_inc_reg, cur_inc_next;
    logic [2:0]  alarm_inc_reg, alarm_inc_next;
    logic [2:0]  flash_reg;
    logic        disp_alarm_reg, run_mode_reg, beep_reg;
    logic        consumed, set_ok, add_ok, beep_ok;

    function automatic state_t advance(input state_t s);
        case (s)
            RUN:      return SET_SEC;
            SET_SEC:  return SET_MIN;
            SET_MIN:  return SET_HOUR;
            SET_HOUR: return ALM_SEC;
            ALM_SEC:  return ALM_MIN;
            ALM_MIN:  return ALM_HOUR;
            default:  return RUN;
        endcase
    endfunction

    function automatic logic [2:0] field_of(input state_t s);
        case (s)
            SET_SEC,  ALM_SEC:  return 3'b001;
            SET_MIN,  ALM_MIN:  return 3'b010;
            SET_HOUR, ALM_HOUR: return 3'b100;
            default:            return 3'b000;
        endcase
    endfunction

    function automatic logic is_alarm(input state_t s);
        return (s == ALM_SEC) || (s == ALM_MIN) || (s == ALM_HOUR);
    endfunction

    // armed_reg masks the first cycle after reset so a held button is not an edge
    assign btn = {beep_btn, add_btn, set_btn};
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_edge
            assign btn_edge[gi] = armed_reg & btn[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    assign match_now = (cur_time == alarm_time);

    always_comb begin
        // Any button edge that silences the buzzer does nothing else
        consumed       = ringing_reg & (|btn_edge);
        set_ok         = btn_edge[0] & ~add_btn & ~consumed;
        add_ok         = btn_edge[1] & ~btn_edge[0] & ~consumed;
        beep_ok        = btn_edge[2] & ~consumed & ~set_ok;
        state_next     = state_reg;
        idle_next      = idle_cnt_reg;
        cur_inc_next   = 3'b000;
        alarm_inc_next = 3'b000;
        if (set_ok) begin
            state_next = advance(state_reg);
            idle_next  = 5'd0;
        end else if (state_reg == RUN) begin
            idle_next = 5'd0;
            if (tick_1s)
                cur_inc_next = 3'b001;
        end else if (add_ok) begin
            idle_next = 5'd0;
            if (is_alarm(state_reg))
                alarm_inc_next = field_of(state_reg);
            else
                cur_inc_next = field_of(state_reg);
        end else if (tick_1s) begin
            if (idle_cnt_reg == IDLE_LAST) begin
                state_next = RUN;
                idle_next  = 5'd0;
            end else begin
                idle_next = idle_cnt_reg + 5'd1;
            end
        end
    end

    always_comb begin
        ringing_next  = ringing_reg;
        phase_next    = phase_reg;
        ring_cnt_next = ring_cnt_reg;
        beep_en_next  = beep_en_reg ^ beep_ok;
        if (ringing_reg) begin
            if (consumed || !beep_en_reg || state_reg != RUN ||
                (tick_1s && ring_cnt_reg == RING_LAST)) begin
                ringing_next  = 1'b0;
                phase_next    = 1'b0;
                ring_cnt_next = 6'd0;
            end else if (tick_1s) begin
                ring_cnt_next = ring_cnt_reg + 6'd1;
                phase_next    = ~phase_reg;
            end
        end else if (match_now && !match_reg && beep_en_reg &&
                     state_reg == RUN && state_next == RUN) begin
            ringing_next  = 1'b1;
            phase_next    = 1'b1;
            ring_cnt_next = 6'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= RUN;
            btn_prev_reg   <= 3'b000;
            armed_reg      <= 1'b0;
            idle_cnt_reg   <= 5'd0;
            match_reg      <= 1'b0;
            ringing_reg    <= 1'b0;
            phase_reg      <= 1'b0;
            ring_cnt_reg   <= 6'd0;
            beep_en_reg    <= 1'b0;
            cur_inc_reg    <= 3'b000;
            alarm_inc_reg  <= 3'b000;
            flash_reg      <= 3'b000;
            disp_alarm_reg <= 1'b0;
            run_mode_reg   <= 1'b1;
            beep_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            btn_prev_reg   <= btn;
            armed_reg      <= 1'b1;
            idle_cnt_reg   <= idle_next;
            match_reg      <= match_now;
            ringing_reg    <= ringing_next;
            phase_reg      <= phase_next;
            ring_cnt_reg   <= ring_cnt_next;
            beep_en_reg    <= beep_en_next;
            cur_inc_reg    <= cur_inc_next;
            alarm_inc_reg  <= alarm_inc_next;
            flash_reg      <= field_of(state_next);
            disp_alarm_reg <= is_alarm(state_next);
            run_mode_reg   <= (state_next == RUN);
            beep_reg       <= ringing_next & phase_next;
        end
    end

    assign cur_inc    = cur_inc_reg;
    assign alarm_inc  = alarm_inc_reg;
    assign flash      = flash_reg;
    assign disp_alarm = disp_alarm_reg;
    assign run_mode   = run_mode_reg;
    assign beep_en    = beep_en_reg;
    assign beep       = beep_reg;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: every cycle's expected outputs are queued before the edge
// and popped and compared one time unit after it.
module tb_clock_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst, tick_1s, set_btn, add_btn, beep_btn;
    logic [23:0] cur_time, alarm_time;
    logic [2:0]  cur_inc, alarm_inc, flash;
    logic        disp_alarm, run_mode, beep_en, beep;

    clock_mode_ctrl dut (
        .clk(clk), .rst(rst), .tick_1s(tick_1s),
        .set_btn(set_btn), .add_btn(add_btn), .beep_btn(beep_btn),
        .cur_time(cur_time), .alarm_time(alarm_time),
        .cur_inc(cur_inc), .alarm_inc(alarm_inc), .disp_alarm(disp_alarm),
        .flash(flash), .run_mode(run_mode), .beep_en(beep_en), .beep(beep)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] vec;
        string       tag;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int   cmp_count = 0;
    int   err_count = 0;
    int   mode = 0;
    logic exp_beep_en = 1'b0;
    logic exp_beep = 1'b0;

    function automatic logic [2:0] flash_of(input int m);
        case (m)
            1, 4:    return 3'b001;
            2, 5:    return 3'b010;
            3, 6:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic push_exp(input logic [2:0] ci, input logic [2:0] ai, input string tag);
        sb_entry_t e;
        e.vec = {ci, ai, (mode >= 4), flash_of(mode), (mode == 0), exp_beep_en, exp_beep};
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic compare_pop();
        sb_entry_t   e;
        logic [12:0] got;
        got = {cur_inc, alarm_inc, disp_alarm, flash, run_mode, beep_en, beep};
        if (sb_q.size() == 0) begin
            err_count++;
            $display("FAIL scoreboard_empty: observed %013b required an entry", got);
        end else begin
            e = sb_q.pop_front();
            cmp_count++;
            assert (got === e.vec) else begin
                err_count++;
                $error("FAIL %s: observed %013b expected %013b", e.tag, got, e.vec);
            end
        end
    endtask

    // One clock: expectations are for the outputs after this edge
    task automatic cyc(input logic [2:0] ci, input logic [2:0] ai, input string tag);
        push_exp(ci, ai, tag);
        @(posedge clk);
        #1;
        compare_pop();
        tick_1s = 1'b0;
    endtask

    task automatic check_now(input string tag);
        push_exp(3'b000, 3'b000, tag);
        compare_pop();
    endtask

    task automatic press_set();
        set_btn = 1'b1;
        mode = (mode == 6) ? 0 : mode + 1;
        cyc(3'b000, 3'b000, "set_edge");
        set_btn = 1'b0;
        cyc(3'b000, 3'b000, "set_release");
    endtask

    task automatic press_add(input logic [2:0] ci, input logic [2:0] ai, input string tag);
        add_btn = 1'b1;
        cyc(ci, ai, tag);
        add_btn = 1'b0;
        cyc(3'b000, 3'b000, "add_release");
    endtask

    task automatic press_beep(input string tag);
        beep_btn = 1'b1;
        exp_beep_en = ~exp_beep_en;
        cyc(3'b000, 3'b000, tag);
        beep_btn = 1'b0;
        cyc(3'b000, 3'b000, "beep_release");
    endtask

    task automatic start_ring();
        cur_time = 24'h065959;
        cyc(3'b000, 3'b000, "rearm_no_match");
        cur_time = 24'h070000;
        exp_beep = 1'b1;
        cyc(3'b000, 3'b000, "ring_start");
    endtask

    task automatic ring_tick(input int k, input string tag);
        cyc(3'b000, 3'b000, "ring_gap");
        tick_1s = 1'b1;
        exp_beep = (k < 60) && (k % 2 == 0);
        cyc(3'b001, 3'b000, tag);
    endtask

    initial begin
        rst = 1'b0; tick_1s = 1'b0; set_btn = 1'b1; add_btn = 1'b0; beep_btn = 1'b0;
        cur_time = 24'h000000; alarm_time = 24'h000000;

        // Reset, with set_btn held high across release
        cyc(3'b000, 3'b000, "reset_hold");
        cyc(3'b000, 3'b000, "reset_hold");
        rst = 1'b1;
        cyc(3'b000, 3'b000, "held_set_no_edge");
        cyc(3'b000, 3'b000, "held_set_steady");
        set_btn = 1'b0;
        cyc(3'b000, 3'b000, "set_release_after_reset");

        // RUN forwards ticks as single-cycle seconds pulses
        for (int i = 0; i < 3; i++) begin
            cyc(3'b000, 3'b000, "run_idle");
            tick_1s = 1'b1;
            cyc(3'b001, 3'b000, "run_tick_pulse");
            cyc(3'b000, 3'b000, "run_tick_single");
        end

        // Setting seconds then minutes
        press_set();
        press_add(3'b001, 3'b000, "set_sec_add");
        press_add(3'b001, 3'b000, "set_sec_add");
        press_set();
        press_add(3'b010, 3'b000, "set_min_add");
        add_btn = 1'b1;
        cyc(3'b010, 3'b000, "add_before_set");
        set_btn = 1'b1;
        cyc(3'b000, 3'b000, "set_with_add_high");
        set_btn = 1'b0; add_btn = 1'b0;
        cyc(3'b000, 3'b000, "release_both");
        set_btn = 1'b1; add_btn = 1'b1;
        cyc(3'b000, 3'b000, "set_add_coincide");
        set_btn = 1'b0; add_btn = 1'b0;
        cyc(3'b000, 3'b000, "release_both");
        tick_1s = 1'b1;
        cyc(3'b000, 3'b000, "tick_frozen_set_min");
        press_set();
        press_add(3'b100, 3'b000, "set_hour_add");
        press_set();
        press_add(3'b000, 3'b001, "alm_sec_add");
        press_set();
        press_add(3'b000, 3'b010, "alm_min_add");
        press_set();
        press_add(3'b000, 3'b100, "alm_hour_add");
        press_set();
        press_add(3'b000, 3'b000, "run_add_ignored");

        // Full loop of seven set edges
        for (int i = 0; i < 7; i++) press_set();

        // Idle timeout after 30 ticks in SET_SEC
        press_set();
        for (int i = 1; i <= 30; i++) begin
            cyc(3'b000, 3'b000, "idle_gap");
            if (i == 30) mode = 0;
            tick_1s = 1'b1;
            cyc(3'b000, 3'b000, "idle_tick");
        end
        cyc(3'b000, 3'b000, "after_timeout");

        // Alarm ringing for 60 ticks
        press_beep("beep_en_on");
        alarm_time = 24'h070000;
        start_ring();
        for (int k = 1; k <= 60; k++) ring_tick(k, "ring_tick");
        for (int i = 0; i < 3; i++) cyc(3'b000, 3'b000, "no_retrigger");

        // Add edge silences the buzzer without incrementing
        start_ring();
        for (int k = 1; k <= 4; k++) ring_tick(k, "ring_tick2");
        add_btn = 1'b1;
        exp_beep = 1'b0;
        cyc(3'b000, 3'b000, "add_stops_ring");
        add_btn = 1'b0;
        cyc(3'b000, 3'b000, "add_release");
        tick_1s = 1'b1;
        cyc(3'b001, 3'b000, "tick_after_stop");

        // Beep edge silences without toggling beep_en
        start_ring();
        beep_btn = 1'b1;
        exp_beep = 1'b0;
        cyc(3'b000, 3'b000, "beep_btn_stops_ring");
        beep_btn = 1'b0;
        cyc(3'b000, 3'b000, "beep_release");

        // Set edge silences and leaves the mode alone
        start_ring();
        set_btn = 1'b1;
        exp_beep = 1'b0;
        cyc(3'b000, 3'b000, "set_consumed_by_ring");
        set_btn = 1'b0;
        cyc(3'b000, 3'b000, "set_release");

        // Disarmed alarm does not ring
        press_beep("beep_en_off");
        cur_time = 24'h065959;
        cyc(3'b000, 3'b000, "disarmed_no_match");
        cur_time = 24'h070000;
        cyc(3'b000, 3'b000, "disarmed_no_ring");

        // Asynchronous reset while ringing
        press_beep("beep_en_on");
        start_ring();
        #3 rst = 1'b0;
        #1;
        mode = 0; exp_beep_en = 1'b0; exp_beep = 1'b0;
        check_now("async_reset_ring");
        cyc(3'b000, 3'b000, "reset_hold_ring");
        rst = 1'b1;
        cur_time = 24'h000000;
        cyc(3'b000, 3'b000, "reset_release");

        // Asynchronous reset in ALM_MIN
        press_beep("beep_en_on");
        for (int i = 0; i < 5; i++) press_set();
        #3 rst = 1'b0;
        #1;
        mode = 0; exp_beep_en = 1'b0;
        check_now("async_reset_alm_min");
        cyc(3'b000, 3'b000, "reset_hold_alm");
        rst = 1'b1;
        cyc(3'b000, 3'b000, "reset_release_alm");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
